// File: rtl/prbs8_pkg.sv
// prbs8_pkg: shared definitions for the PRBS-8 receive checker.
//   PRBS8_TAPS : feedback taps of x^8+x^4+x^3+x^2+1 (bits 4,3,2,0 of the history)
//   chk_state_e: checker FSM states
//   SEG_BLANK  : all segments off (active-low)
//   SEG_HEX    : hex digit -> active-low 7-seg pattern, bit0 = a .. bit6 = g
package prbs8_pkg;

  localparam logic [7:0] PRBS8_TAPS = 8'b0001_1101;

  typedef enum logic {
    SYNC  = 1'b0,
    CHECK = 1'b1
  } chk_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational hex digit to active-low 7-segment decoder.
//   hex : 4-bit digit value
//   seg : segment pattern, active-low, bit0 = a .. bit6 = g
module hex_to_seg7
  import prbs8_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // An undriven/unknown digit shows as blank rather than a bogus numeral.
  always_comb begin
    seg = SEG_BLANK;
    for (int i = 0; i < 16; i++) begin
      if (hex == 4'(i)) seg = SEG_HEX[i];
    end
  end

endmodule

// File: rtl/prbs8_checker.sv
// prbs8_checker: self-synchronising checker for the 8-bit Fibonacci PRBS
// stream (s[k+8] = s[k+4]^s[k+3]^s[k+2]^s[k]). Fills an 8-bit history from
// the line, then runs a free local reference and counts mismatches.
//   clk, rst   : clock, asynchronous active-high reset
//   bit_in     : received bit, consumed when bit_valid is high
//   clr_cnt    : synchronous clear of err_cnt (wins over an increment)
//   locked     : high while checking
//   err_pulse  : one-cycle pulse per mismatched bit
//   err_cnt    : saturating mismatch count
//   seg0, seg1 : err_cnt low/high nibble, active-low 7-seg
// Build option: define PRBS_CHK_RESYNC_EN to drop back to SYNC after
// LOSS_THRESH consecutive mismatches; otherwise CHECK is left only by reset.
//
// state | meaning
// SYNC  | shifting received bits into hist until 8 bits held and hist != 0
// CHECK | shifting predicted bits into hist, comparing each received bit
module prbs8_checker
  import prbs8_pkg::*;
#(
  parameter int LOSS_THRESH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic       clr_cnt,
  output logic       locked,
  output logic       err_pulse,
  output logic [7:0] err_cnt,
  output logic [6:0] seg0,
  output logic [6:0] seg1
);

  if (LOSS_THRESH < 1 || LOSS_THRESH > 15) begin : g_thresh_range
    $error("LOSS_THRESH must be in 1..15");
  end

  chk_state_e state;
  logic [7:0] hist;
  logic [3:0] fill_cnt;

  logic       pred;
  logic       mismatch;
  logic [7:0] hist_rx;
  logic [3:0] fill_nxt;

  assign pred     = ^(hist & PRBS8_TAPS);
  assign mismatch = bit_in ^ pred;
  assign hist_rx  = {bit_in, hist[7:1]};
  assign fill_nxt = (fill_cnt == 4'd8) ? 4'd8 : fill_cnt + 4'd1;

`ifdef PRBS_CHK_RESYNC_EN
  logic [3:0] consec;
  logic [3:0] consec_nxt;
  assign consec_nxt = mismatch ? consec + 4'd1 : 4'd0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SYNC;
      hist      <= 8'h00;
      fill_cnt  <= 4'd0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= 8'h00;
`ifdef PRBS_CHK_RESYNC_EN
      consec    <= 4'd0;
`endif
    end else begin
      err_pulse <= 1'b0;
      if (clr_cnt) err_cnt <= 8'h00;

      if (bit_valid) begin
        case (state)
          SYNC: begin
            hist     <= hist_rx;
            fill_cnt <= fill_nxt;
            // An all-zero history would lock the reference at zero forever.
            if (fill_nxt == 4'd8 && hist_rx != 8'h00) begin
              state  <= CHECK;
              locked <= 1'b1;
`ifdef PRBS_CHK_RESYNC_EN
              consec <= 4'd0;
`endif
            end
          end
          CHECK: begin
            hist      <= {pred, hist[7:1]};
            err_pulse <= mismatch;
            if (mismatch && !clr_cnt && err_cnt != 8'hFF)
              err_cnt <= err_cnt + 8'd1;
`ifdef PRBS_CHK_RESYNC_EN
            consec <= consec_nxt;
            if (consec_nxt == 4'(LOSS_THRESH)) begin
              state    <= SYNC;
              locked   <= 1'b0;
              fill_cnt <= 4'd0;
              consec   <= 4'd0;
            end
`endif
          end
          default: state <= SYNC;
        endcase
      end
    end
  end

  hex_to_seg7 u_seg0 (.hex(err_cnt[3:0]), .seg(seg0));
  hex_to_seg7 u_seg1 (.hex(err_cnt[7:4]), .seg(seg1));

endmodule

// File: doc/prbs8_checker.md
Name: prbs8_checker

Overview:
- Serial receive-side checker for the 8-bit Fibonacci PRBS generator.
- The generator emits state bit 0 each step, shifts right, and inserts x = b4^b3^b2^b0 at bit 7. The resulting stream obeys s[k+8] = s[k+4]^s[k+3]^s[k+2]^s[k].
- The checker self-synchronises on the incoming bit stream, then predicts every following bit.
- It counts mismatches and shows the error count on two 7-segment digits.

Parameters:
- LOSS_THRESH, 4, number of consecutive mismatches in CHECK that forces resync (range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- bit_in  in  1  received PRBS bit.
- bit_valid  in  1  bit_in is consumed on this clock edge.
- clr_cnt  in  1  synchronous clear of err_cnt.
- locked  out  1  high while in CHECK.
- err_pulse  out  1  one-cycle pulse per mismatched bit.
- err_cnt  out  8  saturating error count.
- seg0  out  7  err_cnt[3:0] as a hex digit; active-low; bit0 = segment a … bit6 = segment g.
- seg1  out  7  err_cnt[7:4], same encoding as seg0.

Behaviour:
- Reset values (asynchronous):
  - hist = 8'h00, state = SYNC, fill_cnt = 0, consec = 0.
  - locked = 0, err_pulse = 0, err_cnt = 0.
  - seg0 = seg1 = 7'h40 (digit "0").
- Register hist[7:0]: hist[0] holds the oldest bit, hist[7] the newest.
- Prediction: pred = hist[4]^hist[3]^hist[2]^hist[0].
- State SYNC, on bit_valid:
  - hist <= {bit_in, hist[7:1]}; fill_cnt increments and saturates at 8.
  - When the updated fill count reaches 8 and the updated hist != 0: next state is CHECK, locked <= 1, consec <= 0.
  - If the updated hist == 0 (lock-up state), remain in SYNC and keep shifting. Lock is taken on the first valid bit that makes hist non-zero.
  - No error is counted while in SYNC.
- State CHECK, on bit_valid:
  - Reference mode: the predicted bit, not the received bit, is shifted in: hist <= {pred, hist[7:1]}.
  - mismatch = bit_in ^ pred; err_pulse <= mismatch.
  - On mismatch, err_cnt increments, saturating at 8'hFF. consec increments on mismatch and clears to 0 on a match.
- Lock loss: see Optional Feature.
- No bit_valid: all state holds; err_pulse <= 0.
- Latency: err_pulse, err_cnt and locked are registered. They reflect a bit one cycle after the edge on which that bit is accepted. seg0/seg1 are combinational decodes of err_cnt.
- clr_cnt:
  - err_cnt <= 0 and has priority over an increment in the same cycle.
  - err_pulse still fires for a mismatch in that cycle.
  - State, hist and consec are unaffected.
- Back-to-back bit_valid every cycle is supported with no throughput loss.
- Asynchronous reset mid-check returns everything to the reset values immediately; the next bits restart the fill.

Optional Feature:
- Macro: PRBS_CHK_RESYNC_EN.
- Defined: when consec reaches LOSS_THRESH, the next state is SYNC.
  - locked <= 0, fill_cnt <= 0, consec <= 0; hist is retained but refilled.
  - The mismatch that triggers the resync is still counted.
- Undefined:
  - CHECK is left only by reset.
  - The consec register is not built; LOSS_THRESH is ignored.

Decomposition:
- Shared package prbs8_pkg:
  - PRBS8_TAPS = 8'b0001_1101 (taps on bits 4, 3, 2, 0).
  - State enum {SYNC, CHECK}.
  - SEG_BLANK = 7'h7F.
  - Hex-to-segment constant table.
- Sub-module hex_to_seg7: 4-bit hex in, 7-bit active-low segment pattern out, purely combinational. It is instantiated twice.

Test Plan:
- Lock and clean run:
  - Stimulus: reset; drive the generator stream from seed 8'h01 (first bits 1,0,0,0,0,0,0,0,1…) with bit_valid=1 for 600 bits.
  - Response: locked rises one cycle after the 8th valid bit; err_cnt stays 0; seg0 = seg1 = 7'h40.
- Single bit error:
  - Stimulus: after lock, invert one bit.
  - Response: exactly one err_pulse; err_cnt = 1; seg0 = 7'h79; locked stays 1; subsequent bits match.
- Resync (PRBS_CHK_RESYNC_EN, LOSS_THRESH=4):
  - Stimulus: invert 4 consecutive bits, then drive a clean stream whose phase has jumped.
  - Response: err_cnt = 4; locked falls one cycle after the 4th error; relock after 8 more valid bits; no further errors.
- Lock-up guard:
  - Stimulus: reset; drive 20 valid 0-bits, then a single 1.
  - Response: locked = 0 throughout the zeros; locked = 1 one cycle after the 1 is accepted.
- Saturation and clear:
  - Stimulus: force 300 mismatches.
  - Response: err_cnt = 8'hFF; seg0 = seg1 = 7'h0E.
  - Stimulus: assert clr_cnt in the same cycle as a mismatch.
  - Response: err_cnt = 0 and err_pulse = 1.
- Gaps and reset:
  - Stimulus: toggle bit_valid randomly 50% during a clean stream.
  - Response: no errors.
  - Stimulus: assert rst asynchronously between clock edges mid-CHECK.
  - Response: outputs take their reset values before the next edge.
